mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative multiply/divide unit in the EX stage, directly upstream of the HI/LO register file.
//  Executes MULT/MULTU/DIV/DIVU over multiple cycles and holds EX via stallreq while busy.
//  Passes MTHI/MTLO through in the same cycle.
//  Drives the EX-stage HI/LO write port (hi_we/lo_we/hi_out/lo_out) that the HI/LO file forwards from.
// PARAMETERS
//  WIDTH   32  operand width; the product and the quotient/remainder pair are 2*WIDTH
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-low reset
//  flush      in   1        cancel the in-flight op (exception/branch squash in EX)
//  ex_hold    in   1        EX held by a downstream stall; a finished result must be held
//  op_mult    in   1        signed multiply in EX (one-hot with the other op_* inputs)
//  op_multu   in   1        unsigned multiply
//  op_div     in   1        signed divide
//  op_divu    in   1        unsigned divide
//  op_mthi    in   1        move rs_data to HI
//  op_mtlo    in   1        move rs_data to LO
//  rs_data    in   WIDTH    operand A (multiplicand/dividend) after forwarding
//  rt_data    in   WIDTH    operand B (multiplier/divisor) after forwarding
//  hi_we      out  1        HI write enable (EX forwarding port)
//  lo_we      out  1        LO write enable
//  hi_out     out  WIDTH    HI value: product[63:32] or remainder
//  lo_out     out  WIDTH    LO value: product[31:0] or quotient
//  stallreq   out  1        request to stall IF..EX
//  busy       out  1        FSM is not in IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, counter=0, datapath registers=0.
//    All outputs 0 while in reset.
//  - FSM states: IDLE, MUL, DIV, DONE.
//    - IDLE --mul op--> MUL.
//    - IDLE --div op, rt!=0--> DIV.
//    - IDLE --div op, rt==0--> DONE.
//    - MUL/DIV --count==WIDTH-1--> DONE.
//    - DONE --!ex_hold--> IDLE.
//    - DONE --ex_hold--> DONE.
//    - Any state --flush--> IDLE. flush has priority over every transition and the counter
//      clears. hi_we/lo_we=0 in any cycle with flush=1.
//  - Issue cycle T (IDLE with a mul/div op):
//    - stallreq=1 combinationally.
//    - Latch |rs|, |rt| (abs only for signed ops) and the result sign flags.
//    - counter=0.
//  - MUL: radix-2 shift-add, one bit per cycle; 64-bit accumulator.
//  - DIV: restoring radix-2; {rem,quot} shift register of 2*WIDTH+1 bits; one quotient bit per cycle.
//  - stallreq=1 in the issue cycle and in every MUL/DIV cycle (WIDTH cycles). stallreq=0 in DONE.
//  - DONE:
//    - hi_we=lo_we=1; results valid combinationally from registers.
//    - Held stable every cycle while ex_hold=1.
//    - Nominal latency: result valid at T+WIDTH+1 (T+33); the op occupies EX for WIDTH+2 cycles.
//  - Sign fix-up, applied in DONE only:
//    - mult: negate the 64-bit product if sign(rs)^sign(rt).
//    - div: quotient negated if sign(rs)^sign(rt); remainder takes sign(rs).
//  - Divide by zero (decided): no iteration; DONE at T+1 with hi_out=rs_data and lo_out=all ones.
//  - MTHI/MTLO in IDLE: single-cycle, no stall.
//    - hi_we (or lo_we)=1, out=rs_data.
//    - The other enable stays 0.
//  - Op inputs are ignored while not in IDLE; the held instruction stays in EX, so it is never re-issued.
//    After DONE->IDLE the next EX instruction issues normally.
//  - Most-negative operands (0x80000000) are handled via WIDTH+1-bit abs. div 0x80000000/-1 gives
//    lo=0x80000000, hi=0.
// STRUCTURE
//  - The following go in lib/defines.vh alongside the existing stall constants:
//    - state encodings (MDU_IDLE/MUL/DIV/DONE);
//    - the MDU op one-hot field layout;
//    - the DIV0 lo constant.
//  - One sub-module, iter_div_core: restoring divider (start, dividend, divisor -> quot, rem, done).
//  - The multiply datapath and FSM stay in mul_div_unit.
// TESTING
//  1. multu rs=0xFFFFFFFF rt=2:
//     - stallreq=1 for cycles T..T+32;
//     - at T+33: hi_we=lo_we=1, hi=0x00000001, lo=0xFFFFFFFE.
//  2. mult rs=-3 rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 at T+33.
//     mult 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
//  3. div rs=-7 rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     divu 100/7 -> lo=14, hi=2.
//  4. divu rs=100 rt=0 -> DONE at T+1: hi=100, lo=0xFFFFFFFF; stallreq=1 only at T.
//  5. Interruptions:
//     - flush at T+10 of a div -> IDLE next cycle, no hi_we/lo_we pulse, stallreq=0.
//     - rst low at T+5 -> all outputs 0 immediately.
//  6. ex_hold=1 for 3 cycles in DONE -> we=1 and results stable throughout.
//     Then mthi rs=0x1234 -> hi_we=1, lo_we=0, hi=0x1234, no stall.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM encoding,
// one-hot op field layout and the divide-by-zero LO fill value.
package mul_div_unit_pkg;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

    // Bit positions inside the one-hot op vector assembled from the op_* inputs
    localparam int OP_MULT  = 0;
    localparam int OP_MULTU = 1;
    localparam int OP_DIV   = 2;
    localparam int OP_DIVU  = 3;
    localparam int OP_MTHI  = 4;
    localparam int OP_MTLO  = 5;
    localparam int OP_W     = 6;

    // Every LO bit takes this value after a divide by zero
    localparam logic DIV0_LO_FILL = 1'b1;

endpackage

// File: rtl/mul_div_unit_div.sv
// Restoring radix-2 divider on unsigned magnitudes: one quotient bit per cycle,
// {rem, quot} kept in a single 2*WIDTH+1 bit shift register.
module iter_div_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             done
);

    logic [2*WIDTH:0] sr_q, sr_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             fits;

    assign rem_sh = {sr_q[2*WIDTH-1:WIDTH], sr_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs_q};
    // The guard bit sr_q[2*WIDTH] is always 0 since rem < divisor between steps
    assign fits   = sr_q[2*WIDTH] | (rem_sh >= {1'b0, dvs_q});
    assign done   = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign quot   = sr_q[WIDTH-1:0];
    assign rem    = sr_q[2*WIDTH-1:WIDTH];

    // NOTE: every signal written here gets its default first, so no latch is inferred.
    always_comb begin
        sr_d  = sr_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (abort) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (start) begin
            sr_d  = {{(WIDTH + 1){1'b0}}, dividend};
            dvs_d = divisor;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            sr_d  = {(fits ? trial : rem_sh), sr_q[WIDTH-2:0], fits};
            cnt_d = cnt_q + 1'b1;
            if (done) begin
                run_d = 1'b0;
                cnt_d = '0;
            end
        end
    end

    // NOTE: state uses non-blocking assignments; datapath registers are reset too so
    // nothing reads X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit with MTHI/MTLO pass-through;
// drives the HI/LO forwarding write port and stalls the front of the pipe while busy.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ex_hold,
    input  logic             op_mult,
    input  logic             op_multu,
    input  logic             op_div,
    input  logic             op_divu,
    input  logic             op_mthi,
    input  logic             op_mtlo,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             stallreq,
    output logic             busy
);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   rs_raw_q, rs_raw_d;
    logic               neg_q, neg_d;
    logic               rs_neg_q, rs_neg_d;
    logic               is_div_q, is_div_d;
    logic               div0_q, div0_d;

    logic [OP_W-1:0]  op_vec;
    logic             is_mul_op, is_div_op, signed_op, rs_neg, rt_neg, rt_zero;
    logic [WIDTH-1:0] rs_abs, rt_abs;
    logic [WIDTH:0]   mul_sum;
    logic             div_start, div_done;
    logic [WIDTH-1:0] div_quot, div_rem;

    assign op_vec    = {op_mtlo, op_mthi, op_divu, op_div, op_multu, op_mult};
    assign is_mul_op = op_vec[OP_MULT] | op_vec[OP_MULTU];
    assign is_div_op = op_vec[OP_DIV] | op_vec[OP_DIVU];
    assign signed_op = op_vec[OP_MULT] | op_vec[OP_DIV];
    assign rs_neg    = signed_op & rs_data[WIDTH-1];
    assign rt_neg    = signed_op & rt_data[WIDTH-1];
    assign rs_abs    = rs_neg ? -rs_data : rs_data;
    assign rt_abs    = rt_neg ? -rt_data : rt_data;
    assign rt_zero   = (rt_data == '0);
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign div_start = !flush && (state_q == MDU_IDLE) && is_div_op && !rt_zero;

    iter_div_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
        .clk      (clk),
        .rst_n    (rst),
        .start    (div_start),
        .abort    (flush),
        .dividend (rs_abs),
        .divisor  (rt_abs),
        .quot     (div_quot),
        .rem      (div_rem),
        .done     (div_done)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        rs_raw_d = rs_raw_q;
        neg_d    = neg_q;
        rs_neg_d = rs_neg_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        case (state_q)
            MDU_IDLE: if (is_mul_op || is_div_op) begin
                mcand_d  = rs_abs;
                acc_d    = {{WIDTH{1'b0}}, rt_abs};
                rs_raw_d = rs_data;
                neg_d    = rs_neg ^ rt_neg;
                rs_neg_d = rs_neg;
                is_div_d = is_div_op;
                div0_d   = is_div_op && rt_zero;
                cnt_d    = '0;
                state_d  = is_mul_op ? MDU_MUL : (rt_zero ? MDU_DONE : MDU_DIV);
            end
            MDU_MUL: begin
                // Shift-add: add the multiplicand on a set LSB, then shift the pair right
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = MDU_DONE;
                end
            end
            MDU_DIV:  if (div_done) state_d = MDU_DONE;
            MDU_DONE: if (!ex_hold) state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
        if (flush) begin
            state_d = MDU_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            rs_raw_q <= '0;
            neg_q    <= 1'b0;
            rs_neg_q <= 1'b0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            rs_raw_q <= rs_raw_d;
            neg_q    <= neg_d;
            rs_neg_q <= rs_neg_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // Sign fix-up is applied on the way out, so DONE results stay purely combinational
    always_comb begin
        prod   = neg_q ? -acc_q : acc_q;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (div0_q) begin
            res_hi = rs_raw_q;
            res_lo = {WIDTH{DIV0_LO_FILL}};
        end else if (is_div_q) begin
            res_hi = rs_neg_q ? -div_rem : div_rem;
            res_lo = neg_q ? -div_quot : div_quot;
        end
    end

    always_comb begin
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_out   = '0;
        lo_out   = '0;
        stallreq = 1'b0;
        busy     = 1'b0;
        if (rst) begin
            busy = (state_q != MDU_IDLE);
            case (state_q)
                MDU_IDLE: begin
                    if (op_vec[OP_MTHI]) begin
                        hi_we  = 1'b1;
                        hi_out = rs_data;
                    end
                    if (op_vec[OP_MTLO]) begin
                        lo_we  = 1'b1;
                        lo_out = rs_data;
                    end
                    stallreq = is_mul_op | is_div_op;
                end
                MDU_MUL, MDU_DIV: stallreq = 1'b1;
                MDU_DONE: begin
                    hi_we  = 1'b1;
                    lo_we  = 1'b1;
                    hi_out = res_hi;
                    lo_out = res_lo;
                end
                default: ;
            endcase
            if (flush) begin
                hi_we    = 1'b0;
                lo_we    = 1'b0;
                stallreq = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized
// mul/div traffic compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0, ex_hold = 1'b0;
    logic        op_mult = 1'b0, op_multu = 1'b0, op_div = 1'b0, op_divu = 1'b0;
    logic        op_mthi = 1'b0, op_mtlo = 1'b0;
    logic [31:0] rs_data = '0, rt_data = '0;
    logic        hi_we, lo_we, stallreq, busy;
    logic [31:0] hi_out, lo_out;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_hold(ex_hold),
        .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
        .op_mthi(op_mthi), .op_mtlo(op_mtlo), .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we), .hi_out(hi_out), .lo_out(lo_out),
        .stallreq(stallreq), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // kind: 0 mult, 1 multu, 2 div, 3 divu
    function automatic void model(input int kind, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output int lat);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lat = 33;
        case (kind)
            0: p = 64'(sa * sb);
            1: p = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                    lat = 1;
                end else if (kind == 2) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end else begin
                    p = {a % b, a / b};
                end
            end
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    task automatic set_op(input int kind);
        op_mult  = (kind == 0);
        op_multu = (kind == 1);
        op_div   = (kind == 2);
        op_divu  = (kind == 3);
    endtask

    task automatic clear_ops();
        {op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo} = '0;
    endtask

    // Issue one op, hold it in EX while stalled, check latency, stall window and results;
    // optionally hold the finished result with ex_hold for hold_cycles cycles.
    task automatic run_op(input string tag, input int kind, input logic [31:0] a,
                          input logic [31:0] b, input int hold_cycles);
        logic [31:0] exp_hi, exp_lo;
        int          lat, cyc;
        logic        stall_gap;
        model(kind, a, b, exp_hi, exp_lo, lat);
        @(negedge clk);
        set_op(kind);
        rs_data = a;
        rt_data = b;
        #1;
        check({tag, ".issue_stall"}, stallreq, 1'b1);
        cyc = 0;
        stall_gap = 1'b0;
        while (!hi_we && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!hi_we && !stallreq) stall_gap = 1'b1;
        end
        check({tag, ".latency"}, 32'(cyc), 32'(lat));
        check({tag, ".stall_window"}, stall_gap, 1'b0);
        check({tag, ".done_stall"}, stallreq, 1'b0);
        check({tag, ".lo_we"}, lo_we, 1'b1);
        check({tag, ".hi"}, hi_out, exp_hi);
        check({tag, ".lo"}, lo_out, exp_lo);
        clear_ops();
        rs_data = $urandom;
        rt_data = $urandom;
        if (hold_cycles > 0) begin
            ex_hold = 1'b1;
            for (int i = 0; i < hold_cycles; i++) begin
                @(posedge clk);
                #1;
                check({tag, ".hold_we"}, {31'd0, hi_we & lo_we}, 32'd1);
                check({tag, ".hold_hi"}, hi_out, exp_hi);
                check({tag, ".hold_lo"}, lo_out, exp_lo);
            end
            ex_hold = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, ".back_idle"}, busy, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 300));
        return $urandom;
    endfunction

    initial begin
        logic     seen_we;
        // Reset: outputs must be zero even with an op presented
        op_mthi = 1'b1;
        op_mult = 1'b1;
        rs_data = 32'hDEAD_BEEF;
        #12;
        check("rst.hi_we", hi_we, 1'b0);
        check("rst.stallreq", stallreq, 1'b0);
        check("rst.hi_out", hi_out, 32'd0);
        check("rst.busy", busy, 1'b0);
        clear_ops();
        @(negedge clk);
        rst = 1'b1;

        run_op("multu_ff_x2", 1, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("mult_m3_x5", 0, 32'hFFFF_FFFD, 32'd5, 0);
        run_op("mult_minmin", 0, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("div_m7_2", 2, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_100_7", 3, 32'd100, 32'd7, 0);
        run_op("divu_by0", 3, 32'd100, 32'd0, 0);
        run_op("div_min_m1", 2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div_by0_neg", 2, 32'hFFFF_FF00, 32'd0, 0);
        run_op("div_hold", 2, 32'd1000, 32'hFFFF_FFFD, 3);

        // MTHI right after a held result
        @(negedge clk);
        op_mthi = 1'b1;
        rs_data = 32'h0000_1234;
        #1;
        check("mthi.hi_we", hi_we, 1'b1);
        check("mthi.lo_we", lo_we, 1'b0);
        check("mthi.hi_out", hi_out, 32'h0000_1234);
        check("mthi.stall", stallreq, 1'b0);
        @(negedge clk);
        op_mthi = 1'b0;
        op_mtlo = 1'b1;
        rs_data = 32'hCAFE_0001;
        #1;
        check("mtlo.lo_we", lo_we, 1'b1);
        check("mtlo.hi_we", hi_we, 1'b0);
        check("mtlo.lo_out", lo_out, 32'hCAFE_0001);
        clear_ops();

        // Flush at T+10 of a divide: no write pulse, back to idle
        @(negedge clk);
        op_div = 1'b1;
        rs_data = 32'd12345;
        rt_data = 32'd17;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush.we", {30'd0, hi_we, lo_we}, 32'd0);
        clear_ops();
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        check("flush.stall_after", stallreq, 1'b0);
        check("flush.busy_after", busy, 1'b0);
        seen_we = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (hi_we || lo_we) seen_we = 1'b1;
        end
        check("flush.no_late_we", seen_we, 1'b0);

        // Async reset at T+5 of a multiply, with the op still held in EX
        @(negedge clk);
        op_mult = 1'b1;
        rs_data = 32'd9;
        rt_data = 32'd9;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst5.stall", stallreq, 1'b0);
        check("rst5.busy", busy, 1'b0);
        check("rst5.we", {30'd0, hi_we, lo_we}, 32'd0);
        check("rst5.outs", hi_out | lo_out, 32'd0);
        clear_ops();
        @(negedge clk);
        rst = 1'b1;
        run_op("after_rst", 1, 32'd6, 32'd7, 0);

        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rand%0d", i), int'($urandom_range(0, 3)), pick(), pick(),
                   ($urandom_range(0, 7) == 0) ? 2 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
